ahb_slave_if: RTL and testbench

AHB-side front end of the AHB-to-APB bridge: registers AHB address, data and direction into a two-stage pipeline, decodes the address into a one-hot peripheral select, and raises `valid` for the APB controller downstream. It also owns the AHB two-cycle ERROR response for unmapped addresses and a wrapping count of accepted transfers. Sits between the AHB interconnect and the APB controller, which consumes `valid`, `haddr`, `haddr1`, `haddr2`, `hwdata1`, `hwdata2`, `hwritereg` and `tempselx`.

---
 rtl/ahb_slave_if.sv | 162 ++++++++++++++++
 tb/tb_ahb_slave_if.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge.
// Registers the AHB address, write data and direction into a two-stage
// pipeline, decodes the address into a one-hot peripheral select, and
// raises valid for the APB controller. Unmapped active transfers get the
// two-cycle AHB ERROR response. Accepted mapped transfers are counted.
//
// Handshake: a transfer is accepted on a rising edge where hreadyin=1 and
// htrans is NONSEQ/SEQ. valid is combinational and is only offered while
// the error FSM is in OKAY. The controller consumes valid on the same edge.
// Both hresp and err_hready are decoded straight from the error state, so
// the pair uniquely identifies the state (00/1 OKAY, 01/0 ERR1, 01/1 ERR2).
module ahb_slave_if #(
   parameter logic [31:0] BASE0 = 32'h8000_0000,
   parameter logic [31:0] BASE1 = 32'h8400_0000,
   parameter logic [31:0] BASE2 = 32'h8800_0000,
   parameter logic [31:0] WIN   = 32'h0400_0000
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hwrite,
   input  logic        hreadyin,
   input  logic [1:0]  htrans,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   input  logic [31:0] prdata,
   output logic        valid,
   output logic [31:0] haddr1,
   output logic [31:0] haddr2,
   output logic [31:0] hwdata1,
   output logic [31:0] hwdata2,
   output logic        hwritereg,
   output logic [2:0]  tempselx,
   output logic [31:0] hrdata,
   output logic [1:0]  hresp,
   output logic        err_hready,
   output logic [7:0]  xfer_cnt
);

   typedef enum logic [1:0] {
      ST_OKAY = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] haddr1_q, haddr1_d;
   logic [31:0] haddr2_q, haddr2_d;
   logic [31:0] hwdata1_q, hwdata1_d;
   logic [31:0] hwdata2_q, hwdata2_d;
   logic        hwritereg_q, hwritereg_d;
   logic [7:0]  xfer_cnt_q, xfer_cnt_d;
   logic        active;
   logic        mapped;

   // Address decode: offset-from-base compare works for any base, even one
   // not aligned to the window size, and never overflows at the top of memory.
   always_comb begin
      tempselx = 3'b000;
      if ((haddr - BASE0) < WIN) begin
         tempselx = 3'b001;
      end else if ((haddr - BASE1) < WIN) begin
         tempselx = 3'b010;
      end else if ((haddr - BASE2) < WIN) begin
         tempselx = 3'b100;
      end
   end

   // Transfer qualification: only NONSEQ/SEQ with the bus ready count.
   always_comb begin
      active = hreadyin & ((htrans == 2'b10) | (htrans == 2'b11));
      mapped = (tempselx != 3'b000);
      valid  = active & mapped & (state_q == ST_OKAY);
      hrdata = prdata;
   end

   // Error FSM state register; reset drops straight back to OKAY.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= ST_OKAY;
      end else begin
         state_q <= state_d;
      end
   end

   // Error FSM next state: transfers seen during ERR1/ERR2 are ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OKAY: if (active && !mapped) state_d = ST_ERR1;
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = ST_OKAY;
         default: state_d = ST_OKAY;
      endcase
   end

   // Error FSM outputs: first error cycle stretches the bus, second releases it.
   always_comb begin
      hresp      = 2'b00;
      err_hready = 1'b1;
      case (state_q)
         ST_ERR1: begin
            hresp      = 2'b01;
            err_hready = 1'b0;
         end
         ST_ERR2: begin
            hresp      = 2'b01;
            err_hready = 1'b1;
         end
         default: begin
            hresp      = 2'b00;
            err_hready = 1'b1;
         end
      endcase
   end

   // Pipeline and counter next values: pipeline advances only on hreadyin.
   always_comb begin
      haddr1_d    = haddr1_q;
      haddr2_d    = haddr2_q;
      hwdata1_d   = hwdata1_q;
      hwdata2_d   = hwdata2_q;
      hwritereg_d = hwritereg_q;
      xfer_cnt_d  = xfer_cnt_q;
      if (hreadyin) begin
         haddr1_d    = haddr;
         haddr2_d    = haddr1_q;
         hwdata1_d   = hwdata;
         hwdata2_d   = hwdata1_q;
         hwritereg_d = hwrite;
      end
      if (valid) begin
         xfer_cnt_d = xfer_cnt_q + 8'd1;
      end
   end

   // Pipeline and counter registers.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         haddr1_q    <= 32'h0;
         haddr2_q    <= 32'h0;
         hwdata1_q   <= 32'h0;
         hwdata2_q   <= 32'h0;
         hwritereg_q <= 1'b0;
         xfer_cnt_q  <= 8'h0;
      end else begin
         haddr1_q    <= haddr1_d;
         haddr2_q    <= haddr2_d;
         hwdata1_q   <= hwdata1_d;
         hwdata2_q   <= hwdata2_d;
         hwritereg_q <= hwritereg_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   assign haddr1    = haddr1_q;
   assign haddr2    = haddr2_q;
   assign hwdata1   = hwdata1_q;
   assign hwdata2   = hwdata2_q;
   assign hwritereg = hwritereg_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// that (combinational) or 1 ns after the next rising edge (registered).
module tb_ahb_slave_if;

   localparam logic [31:0] BASE0 = 32'h8000_0000;
   localparam logic [31:0] BASE1 = 32'h8400_0000;
   localparam logic [31:0] BASE2 = 32'h8800_0000;
   localparam logic [1:0]  IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

   logic        hclk, hreset, hwrite, hreadyin;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata, prdata;
   logic        valid, hwritereg, err_hready;
   logic [31:0] haddr1, haddr2, hwdata1, hwdata2, hrdata;
   logic [2:0]  tempselx;
   logic [1:0]  hresp;
   logic [7:0]  xfer_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_cnt  = 8'h0;

   // Scoreboard queues: accepted address / data / direction, oldest first.
   logic [31:0] exp_q[$];
   logic [31:0] dat_q[$];
   logic        wr_q[$];

   ahb_slave_if dut (
      .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
      .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
      .valid(valid), .haddr1(haddr1), .haddr2(haddr2), .hwdata1(hwdata1),
      .hwdata2(hwdata2), .hwritereg(hwritereg), .tempselx(tempselx),
      .hrdata(hrdata), .hresp(hresp), .err_hready(err_hready), .xfer_cnt(xfer_cnt)
   );

   // Clock and watchdog
   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference decode written from the window map (top six address bits).
   function automatic logic [2:0] model_sel(input logic [31:0] a);
      case (a[31:26])
         6'b100000: model_sel = 3'b001;
         6'b100001: model_sel = 3'b010;
         6'b100010: model_sel = 3'b100;
         default:   model_sel = 3'b000;
      endcase
   endfunction

   // Driver tasks
   task automatic set_in(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic r, input logic [31:0] d);
      haddr = a; htrans = t; hwrite = w; hreadyin = r; hwdata = d;
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic test_reset();
      logic exp_v;
      hreset = 1'b1;
      haddr = $urandom(); hwdata = $urandom(); prdata = $urandom();
      htrans = 2'($urandom_range(0, 3)); hwrite = 1'($urandom_range(0, 1));
      hreadyin = 1'($urandom_range(0, 1));
      repeat (2) @(posedge hclk);
      #1;
      n_checks++; if (haddr1 !== 32'h0 || haddr2 !== 32'h0) begin n_fail++;
         $display("FAIL reset_haddr: haddr1=%h haddr2=%h want 0", haddr1, haddr2); end
      n_checks++; if (hwdata1 !== 32'h0 || hwdata2 !== 32'h0) begin n_fail++;
         $display("FAIL reset_hwdata: hwdata1=%h hwdata2=%h want 0", hwdata1, hwdata2); end
      n_checks++; if (hwritereg !== 1'b0) begin n_fail++;
         $display("FAIL reset_hwritereg: got %b want 0", hwritereg); end
      n_checks++; if (xfer_cnt !== 8'h0) begin n_fail++;
         $display("FAIL reset_cnt: got %h want 00", xfer_cnt); end
      n_checks++; if (hresp !== 2'b00 || err_hready !== 1'b1) begin n_fail++;
         $display("FAIL reset_resp: hresp=%b err_hready=%b want 00/1", hresp, err_hready); end
      exp_v = hreadyin && htrans[1] && (model_sel(haddr) != 3'b000);
      n_checks++; if (valid !== exp_v || tempselx !== model_sel(haddr)) begin n_fail++;
         $display("FAIL reset_valid: valid=%b sel=%b want %b/%b", valid, tempselx, exp_v, model_sel(haddr)); end
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      hreset = 1'b0;
      exp_cnt = 8'h0;
      tick();
   endtask

   task automatic test_decode();
      logic [31:0] addrs[3];
      logic [2:0]  sels[3];
      addrs[0] = 32'h8000_0010; sels[0] = 3'b001;
      addrs[1] = 32'h8400_0000; sels[1] = 3'b010;
      addrs[2] = 32'h8BFF_FFFC; sels[2] = 3'b100;
      for (int i = 0; i < 3; i++) begin
         set_in(addrs[i], NONSEQ, 1'b1, 1'b1, 32'hA000_0000 + 32'(i));
         #1;
         n_checks++; if (tempselx !== sels[i] || valid !== 1'b1) begin n_fail++;
            $display("FAIL decode_%0d: sel=%b valid=%b want %b/1", i, tempselx, valid, sels[i]); end
         exp_cnt++;
         tick();
      end
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++;
         $display("FAIL decode_cnt: got %h want %h", xfer_cnt, exp_cnt); end
      // Window edges, presented as IDLE so no error is raised.
      set_in(32'h7FFF_FFFC, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (tempselx !== 3'b000 || valid !== 1'b0) begin n_fail++;
         $display("FAIL decode_below: sel=%b valid=%b want 000/0", tempselx, valid); end
      set_in(32'h8C00_0000, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (tempselx !== 3'b000) begin n_fail++;
         $display("FAIL decode_above: sel=%b want 000", tempselx); end
      set_in(32'h87FF_FFFF, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (tempselx !== 3'b010) begin n_fail++;
         $display("FAIL decode_top1: sel=%b want 010", tempselx); end
      tick();
   endtask

   task automatic test_pipeline();
      localparam int NP = 10;
      logic [31:0] pa[NP];
      logic [31:0] pd[NP];
      logic        pr[NP];
      logic        pw[NP];
      logic [31:0] bases[3];
      bases[0] = BASE0; bases[1] = BASE1; bases[2] = BASE2;
      pa[0] = 32'h8000_0000; pd[0] = 32'h1111_0000; pr[0] = 1'b1; pw[0] = 1'b1;
      pa[1] = 32'h8000_0004; pd[1] = 32'h2222_0000; pr[1] = 1'b1; pw[1] = 1'b0;
      pa[2] = 32'h9000_0000; pd[2] = 32'hDEAD_BEEF; pr[2] = 1'b0; pw[2] = 1'b1;
      for (int i = 3; i < NP; i++) begin
         pa[i] = bases[$urandom_range(0, 2)] + (32'($urandom_range(0, 65535)) << 2);
         pd[i] = $urandom();
         pr[i] = 1'($urandom_range(0, 1));
         pw[i] = 1'($urandom_range(0, 1));
      end
      exp_q.delete(); dat_q.delete(); wr_q.delete();
      for (int i = 0; i < NP; i++) begin
         set_in(pa[i], NONSEQ, pw[i], pr[i], pd[i]);
         #1;
         n_checks++; if (valid !== pr[i]) begin n_fail++;
            $display("FAIL pipe_valid_%0d: got %b want %b", i, valid, pr[i]); end
         if (pr[i]) begin
            exp_q.push_back(pa[i]); dat_q.push_back(pd[i]); wr_q.push_back(pw[i]);
            exp_cnt++;
         end
         tick();
         n_checks++; if (haddr1 !== exp_q[exp_q.size()-1] || hwdata1 !== dat_q[dat_q.size()-1]) begin n_fail++;
            $display("FAIL pipe_stage1_%0d: haddr1=%h hwdata1=%h want %h/%h", i, haddr1, hwdata1,
                     exp_q[exp_q.size()-1], dat_q[dat_q.size()-1]); end
         n_checks++; if (hwritereg !== wr_q[wr_q.size()-1]) begin n_fail++;
            $display("FAIL pipe_hwritereg_%0d: got %b want %b", i, hwritereg, wr_q[wr_q.size()-1]); end
         if (exp_q.size() >= 2) begin
            n_checks++; if (haddr2 !== exp_q[exp_q.size()-2] || hwdata2 !== dat_q[dat_q.size()-2]) begin n_fail++;
               $display("FAIL pipe_stage2_%0d: haddr2=%h hwdata2=%h want %h/%h", i, haddr2, hwdata2,
                        exp_q[exp_q.size()-2], dat_q[dat_q.size()-2]); end
         end
         n_checks++; if (hresp !== 2'b00) begin n_fail++;
            $display("FAIL pipe_noerr_%0d: hresp=%b want 00", i, hresp); end
         while (exp_q.size() > 2) begin
            void'(exp_q.pop_front()); void'(dat_q.pop_front()); void'(wr_q.pop_front());
         end
      end
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++;
         $display("FAIL pipe_cnt: got %h want %h", xfer_cnt, exp_cnt); end
      tick();
   endtask

   task automatic test_error();
      set_in(32'h9000_0000, NONSEQ, 1'b1, 1'b1, 32'h0);
      #1;
      n_checks++; if (valid !== 1'b0 || tempselx !== 3'b000) begin n_fail++;
         $display("FAIL err_addr_phase: valid=%b sel=%b want 0/000", valid, tempselx); end
      tick();
      // Mapped transfer during ERR1 is ignored.
      set_in(32'h8000_0100, NONSEQ, 1'b1, 1'b1, 32'h0);
      #1;
      n_checks++; if (hresp !== 2'b01 || err_hready !== 1'b0) begin n_fail++;
         $display("FAIL err_cycle1: hresp=%b err_hready=%b want 01/0", hresp, err_hready); end
      n_checks++; if (valid !== 1'b0) begin n_fail++;
         $display("FAIL err_valid1: got %b want 0", valid); end
      tick();
      // Unmapped transfer during ERR2 must not restart the error.
      set_in(32'hA000_0000, NONSEQ, 1'b1, 1'b1, 32'h0);
      #1;
      n_checks++; if (hresp !== 2'b01 || err_hready !== 1'b1) begin n_fail++;
         $display("FAIL err_cycle2: hresp=%b err_hready=%b want 01/1", hresp, err_hready); end
      tick();
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (hresp !== 2'b00 || err_hready !== 1'b1) begin n_fail++;
         $display("FAIL err_back_okay: hresp=%b err_hready=%b want 00/1", hresp, err_hready); end
      n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++;
         $display("FAIL err_cnt: got %h want %h", xfer_cnt, exp_cnt); end
      // First address past the last window also errors.
      set_in(32'h8C00_0000, SEQ, 1'b0, 1'b1, 32'h0);
      tick();
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (hresp !== 2'b01 || err_hready !== 1'b0) begin n_fail++;
         $display("FAIL err_edge: hresp=%b err_hready=%b want 01/0", hresp, err_hready); end
      tick();
      tick();
   endtask

   task automatic test_busy_idle();
      logic [31:0] pr;
      set_in(32'h8400_0040, BUSY, 1'b1, 1'b1, 32'h0);
      #1;
      n_checks++; if (valid !== 1'b0) begin n_fail++;
         $display("FAIL busy_valid: got %b want 0", valid); end
      tick();
      set_in(32'h8400_0040, IDLE, 1'b1, 1'b1, 32'h0);
      #1;
      n_checks++; if (valid !== 1'b0) begin n_fail++;
         $display("FAIL idle_valid: got %b want 0", valid); end
      tick();
      set_in(32'h9000_0000, BUSY, 1'b0, 1'b1, 32'h0);
      tick();
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      pr = $urandom();
      prdata = pr;
      #1;
      n_checks++; if (hresp !== 2'b00 || err_hready !== 1'b1) begin n_fail++;
         $display("FAIL busy_noerr: hresp=%b err_hready=%b want 00/1", hresp, err_hready); end
      n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++;
         $display("FAIL busy_cnt: got %h want %h", xfer_cnt, exp_cnt); end
      n_checks++; if (hrdata !== pr) begin n_fail++;
         $display("FAIL hrdata_pass: got %h want %h", hrdata, pr); end
      // Unmapped NONSEQ with hreadyin low: no error.
      set_in(32'h9000_0000, NONSEQ, 1'b0, 1'b0, 32'h0);
      tick();
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (hresp !== 2'b00) begin n_fail++;
         $display("FAIL notready_noerr: hresp=%b want 00", hresp); end
      tick();
   endtask

   task automatic test_wrap();
      hreset = 1'b1;
      #1;
      n_checks++; if (xfer_cnt !== 8'h0) begin n_fail++;
         $display("FAIL wrap_start: got %h want 00", xfer_cnt); end
      hreset = 1'b0;
      exp_cnt = 8'h0;
      for (int i = 0; i < 256; i++) begin
         set_in(BASE1 + 32'(i * 4), SEQ, 1'b1, 1'b1, 32'(i));
         tick();
         exp_cnt++;
         if (i == 254) begin
            n_checks++; if (xfer_cnt !== 8'hFF) begin n_fail++;
               $display("FAIL wrap_ff: got %h want ff", xfer_cnt); end
         end
      end
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (xfer_cnt !== exp_cnt || xfer_cnt !== 8'h00) begin n_fail++;
         $display("FAIL wrap_zero: got %h want 00", xfer_cnt); end
      tick();
   endtask

   task automatic test_reset_mid_error();
      set_in(32'h9000_0000, NONSEQ, 1'b1, 1'b1, 32'h0);
      tick();
      set_in(32'h0, IDLE, 1'b0, 1'b1, 32'h0);
      #1;
      n_checks++; if (hresp !== 2'b01 || err_hready !== 1'b0) begin n_fail++;
         $display("FAIL rst_err_entry: hresp=%b err_hready=%b want 01/0", hresp, err_hready); end
      #1;
      hreset = 1'b1;
      #1;
      n_checks++; if (hresp !== 2'b00 || err_hready !== 1'b1) begin n_fail++;
         $display("FAIL rst_err_immediate: hresp=%b err_hready=%b want 00/1", hresp, err_hready); end
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      exp_cnt = 8'h0;
      tick();
      n_checks++; if (hresp !== 2'b00 || xfer_cnt !== exp_cnt || haddr1 !== 32'h0) begin n_fail++;
         $display("FAIL rst_err_after: hresp=%b cnt=%h haddr1=%h want 00/00/0", hresp, xfer_cnt, haddr1); end
   endtask

   initial begin
      hreset = 1'b1;
      set_in(32'h0, IDLE, 1'b0, 1'b0, 32'h0);
      prdata = 32'h0;
      test_reset();
      test_decode();
      test_pipeline();
      test_error();
      test_busy_idle();
      test_wrap();
      test_reset_mid_error();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
